// File: rtl/sr_latch_ctrl.sv
// Round-robin arbiter that serialises set/clear requests onto one external SR latch
// and checks the latch readback. Optional macro: SR_SKIP_REDUNDANT_EN (skip redundant pulses).
module sr_latch_ctrl #(
  parameter int N_REQ     = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int CW        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  input  logic             Q_fb,
  output logic             S,
  output logic             R,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             req_err,
  output logic             verify_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             op_q, op_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             req_err_q, req_err_d;
  logic             verify_err_q, verify_err_d;

  logic [N_REQ-1:0] eligible;
  logic             conflict;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    win_next;
  logic             win_op;
  int               idx;

  assign eligible = set_req ^ clr_req;
  assign conflict = |(set_req & clr_req);

  // Rotating priority search starting at rr_ptr_q, wrapping at N_REQ.
  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign win_next = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
  assign win_op   = set_req[win_idx];

`ifdef SR_SKIP_REDUNDANT_EN
  logic q_fb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_fb_q <= 1'b0;
    else        q_fb_q <= Q_fb;
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    grant_d      = '0;
    req_err_d    = 1'b0;
    verify_err_d = verify_err_q;

    unique case (state_q)
      IDLE: begin
        req_err_d = conflict;
        if (win_found) begin
          owner_d  = win_idx;
          op_d     = win_op;
          rr_ptr_d = win_next;
`ifdef SR_SKIP_REDUNDANT_EN
          if (win_op == q_fb_q) begin
            state_d = CHECK;
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            state_d = PULSE;
            cnt_d   = CW'(PULSE_CYC - 1);
            s_d     = win_op;
            r_d     = ~win_op;
          end
`else
          state_d = PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
          s_d     = win_op;
          r_d     = ~win_op;
`endif
        end
      end

      // S/R are registered, so the drive for the next cycle is decided here.
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
          s_d   = op_q;
          r_d   = ~op_q;
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      CHECK: begin
        if (Q_fb != op_q) verify_err_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      op_q         <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      req_err_q    <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      s_q          <= s_d;
      r_q          <= r_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      req_err_q    <= req_err_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign S          = s_q;
  assign R          = r_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign req_err    = req_err_q;
  assign verify_err = verify_err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Scoreboard bench for sr_latch_ctrl: directed requests push expected grants,
// a negedge monitor pops and compares them; a behavioural SR latch feeds Q_fb.
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] set_req = '0;
  logic [3:0] clr_req = '0;
  logic       Q_fb;
  logic       S, R, busy, req_err, verify_err;
  logic [3:0] grant;

  logic       q_lat = 1'b0;
  logic       stuck = 1'b0;
  bit         req_err_seen, r_seen, s_seen;
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  sr_latch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_req    (set_req),
    .clr_req    (clr_req),
    .Q_fb       (Q_fb),
    .S          (S),
    .R          (R),
    .grant      (grant),
    .busy       (busy),
    .req_err    (req_err),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (S)      q_lat <= 1'b1;
    else if (R) q_lat <= 1'b0;
  end
  assign Q_fb = stuck ? 1'b0 : q_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    check("s_and_r_exclusive", 32'(S & R), 32'd0);
    if (req_err) req_err_seen = 1'b1;
    if (R)       r_seen = 1'b1;
    if (S)       s_seen = 1'b1;
    if (grant !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("grant_order", 32'(grant), 32'(e));
      end
    end
  end

  // Waits for a grant, drops the served requester's bits, returns in the following IDLE cycle.
  task automatic wait_grant(input string name);
    int n = 0;
    @(negedge clk);
    while (grant === 4'b0000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (grant === 4'b0000) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      set_req = set_req & ~grant;
      clr_req = clr_req & ~grant;
      @(negedge clk);
    end
  endtask

  // Issues a set from the IDLE cycle and checks the cycle-by-cycle S/R/grant pattern.
  task automatic timed_set(input int idx, input bit skip, input string tag);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    exp_q.push_back(oh);
    set_req[idx] = 1'b1;
    if (skip) begin
      @(negedge clk);
      check({tag, "_S"}, 32'(S), 32'd0);
      check({tag, "_grant"}, 32'(grant), 32'(oh));
    end else begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check($sformatf("%s_S_c%0d", tag, k + 1), 32'(S), (k <= 2) ? 32'd1 : 32'd0);
        check($sformatf("%s_R_c%0d", tag, k + 1), 32'(R), 32'd0);
        check($sformatf("%s_grant_c%0d", tag, k + 1), 32'(grant), (k == 4) ? 32'(oh) : 32'd0);
      end
    end
    set_req[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit skip_mode;
`ifdef SR_SKIP_REDUNDANT_EN
    skip_mode = 1'b1;
`else
    skip_mode = 1'b0;
`endif

    // Reset with all requesters asking to set.
    set_req = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_S", 32'(S), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_verify_err", 32'(verify_err), 32'd0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    rst_n = 1'b1;
    repeat (4) wait_grant("t1");

    // Bring the latch to 0, then a single timed set from requester 2.
    exp_q.push_back(4'b0001);
    clr_req = 4'b0001;
    wait_grant("t2_pre");
    timed_set(2, 1'b0, "t2");
    check("t2_q_followed", 32'(Q_fb), 32'd1);
    check("t2_verify_err", 32'(verify_err), 32'd0);

    // Round-robin order 0,1,3 from a pointer at 0 (grant to 3 first wraps it).
    exp_q.push_back(4'b1000);
    clr_req = 4'b1000;
    wait_grant("t3_pre");
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    set_req = 4'b1011;
    repeat (3) wait_grant("t3");
    exp_q.push_back(4'b0001);
    set_req = 4'b0001;
    wait_grant("t3_wrap");

    // Conflicting requester 2 is never served; requester 1 clears the latch.
    req_err_seen = 1'b0;
    r_seen       = 1'b0;
    s_seen       = 1'b0;
    exp_q.push_back(4'b0010);
    set_req = 4'b0100;
    clr_req = 4'b0110;
    wait_grant("t4");
    repeat (10) @(negedge clk);
    check("t4_req_err_pulsed", 32'(req_err_seen), 32'd1);
    check("t4_R_pulsed", 32'(r_seen), 32'd1);
    check("t4_S_quiet", 32'(s_seen), 32'd0);
    check("t4_latch_cleared", 32'(Q_fb), 32'd0);
    set_req = '0;
    clr_req = '0;
    @(negedge clk);

    // Readback stuck at 0: verify_err sets and stays until reset.
    stuck = 1'b1;
    exp_q.push_back(4'b0001);
    set_req = 4'b0001;
    wait_grant("t5");
    check("t5_verify_err_set", 32'(verify_err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_verify_err_sticky", 32'(verify_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_verify_err_reset", 32'(verify_err), 32'd0);
    stuck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during PULSE drops S immediately and no grant follows.
    exp_q.push_back(4'b0001);
    clr_req = 4'b0001;
    wait_grant("t6_pre");
    set_req = 4'b0010;
    @(negedge clk);
    check("t6_S_high_before_reset", 32'(S), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_S_async_drop", 32'(S), 32'd0);
    check("t6_R_async", 32'(R), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    set_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_idle_after_reset", 32'(busy), 32'd0);

    // Redundant set with Q already 1: skipped in skip builds, full pulse otherwise.
    exp_q.push_back(4'b0001);
    set_req = 4'b0001;
    wait_grant("t7_pre");
    check("t7_latch_set", 32'(Q_fb), 32'd1);
    timed_set(1, skip_mode, "t7");
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_verify_err", 32'(verify_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
